fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the 5-stage pipeline. It owns the fetch PC, issues requests on a req/ack instruction-memory handshake and loads the IF/ID pipeline register. It also consumes the hazard unit's stallF/stallD outputs and the decode-stage branch redirect. It never loses or duplicates an instruction under stall, redirect or a slow memory response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- stallF  in  1  hazard unit: hold fetch PC
- stallD  in  1  hazard unit: hold IF/ID register
- pcSrcD  in  1  decode: branch/jump taken
- pcBranchD  in  ADDR_W  decode: redirect target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  request address, stable while imem_req=1
- imem_ack  in  1  response valid; completes the request in the same cycle
- imem_rdata  in  INSTR_W  instruction word, valid with imem_ack
- instrD  out  INSTR_W  IF/ID instruction
- pcPlus4D  out  ADDR_W  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Registers: pcF, reqAddr, drop flag, hold buffer (instr and pc+4), IF/ID (instrD, pcPlus4D, validD), state.
- The redirect is effective only when pcSrcD=1 and stallD=0. Define redir = pcSrcD & ~stallD. If pcSrcD=1 and stallD=1, pcSrcD is ignored.
- States:
  - IDLE: post-reset only. Moves to REQ on the next edge.
  - REQ: imem_req=1, imem_addr=reqAddr.
  - HOLD: word fetched but IF/ID stalled. imem_req=0.
- REQ, ack=1, drop=0, redir=0, stallD=0:
  - IF/ID <= {rdata, reqAddr+4, 1}.
  - pcF and reqAddr advance to reqAddr+4, unless stallF=1.
  - Stay in REQ.
- REQ, ack=1, stallD=1, no redirect: store the word in the hold buffer, go to HOLD.
- REQ, ack=1, drop=1: discard the word, clear drop, reqAddr <= pcF, stay in REQ.
- REQ, ack=0: imem_req stays high and reqAddr is unchanged. Requests are never withdrawn.
- Redirect (any state):
  - pcF <= pcBranchD.
  - IF/ID <= {NOP, 0, 0}.
  - If in REQ with ack=0: set drop=1. The old request completes, then the target is fetched.
  - If in REQ with ack=1: discard the word, reqAddr <= pcBranchD.
  - If in HOLD: discard the buffer, go to REQ at pcBranchD.
- HOLD, stallD falls with no redirect: IF/ID <= buffer, reqAddr <= pcF (already advanced), go to REQ.
- When stallD=1 the IF/ID register is unchanged in every case.
- PC+4 arithmetic is modulo 2^ADDR_W. 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instrD=NOP (all zeros), pcPlus4D=0, validD=0, state IDLE, drop=0.
- Reset is asynchronous. Asserting it mid-request drops the request immediately and the ack is ignored.
- First imem_req=1 occurs in the cycle after the first rising edge following rst_n release.
- Latency: ack in cycle N gives the instruction on instrD/validD in cycle N+1.
- Throughput: 1 instruction/cycle when ack is tied high.
- Redirect penalty: one bubble on validD when the request is acked the same cycle. Longer if a dropped request is still pending.

## Configuration
- FETCH_PERF_EN defined: adds output ports perf_fetched and perf_squashed, each 32 bits, zero at reset, wrapping.
  - perf_fetched increments on every word loaded into IF/ID.
  - perf_squashed increments on every acked word discarded (drop, redirect-with-ack, or discarded hold buffer).
- FETCH_PERF_EN undefined: ports and counters absent, functionality otherwise identical.

## Structure
- Shared package:
  - fetch_state_t enum {IDLE, REQ, HOLD}
  - NOP_INSTR constant (0)
  - PC_INCR constant (4)
- Sub-module if_id_reg: IF/ID register with enable (~stallD), synchronous clear (redir) and asynchronous reset. It is reused by the later decode/execute register work.

## Test plan
- Reset release, ack tied 1: imem_addr goes 0,4,8,C on consecutive cycles; validD=1 from cycle 2; pcPlus4D tracks addr+4.
- stallF=stallD=1 for 3 cycles mid-stream: instrD is frozen and the word acked during the stall is held. No address is skipped or repeated after release.
- ack delayed 3 cycles: imem_req and imem_addr stay stable; validD=0 during the wait; the word appears the cycle after ack.
- pcSrcD=1, pcBranchD=0x100 while ack=0 with a request at 0x20 pending: the 0x20 word is dropped on ack; the next request is 0x100; perf_squashed=1.
- pcSrcD=1 with stallD=1: no redirect. pcSrcD=1 with stallD=0 in HOLD: buffer discarded, validD=0, next fetch at target.
- pcF=0xFFFF_FFFC fetched: pcPlus4D=0 and the next request is 0x0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch front end and the pipeline registers.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'h0000_0004;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load enable, synchronous clear to a bubble, async reset.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc_plus4,
  input  logic               i_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc_plus4,
  output logic               o_valid
);

  // Clear takes priority over load so a squashed slot always becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_instr    <= INSTR_W'(NOP_INSTR);
      o_pc_plus4 <= {ADDR_W{1'b0}};
      o_valid    <= 1'b0;
    end else if (i_clr) begin
      o_instr    <= INSTR_W'(NOP_INSTR);
      o_pc_plus4 <= {ADDR_W{1'b0}};
      o_valid    <= 1'b0;
    end else if (i_en) begin
      o_instr    <= i_instr;
      o_pc_plus4 <= i_pc_plus4;
      o_valid    <= i_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, req/ack imem handshake, hold buffer and IF/ID load.
// Optional FETCH_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               pcSrcD,
  input  logic [ADDR_W-1:0]  pcBranchD,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instrD,
  output logic [ADDR_W-1:0]  pcPlus4D,
  output logic               validD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_squashed
`endif
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc_f;
  logic [ADDR_W-1:0]  w_pc_f_nxt;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [ADDR_W-1:0]  w_req_addr_nxt;
  logic               r_drop;
  logic               w_drop_nxt;
  logic [INSTR_W-1:0] r_hold_instr;
  logic [ADDR_W-1:0]  r_hold_pc4;
  logic               w_hold_we;
  logic               w_load;
  logic [INSTR_W-1:0] w_ld_instr;
  logic [ADDR_W-1:0]  w_ld_pc4;
  logic               w_redir;
  logic [ADDR_W-1:0]  w_req_plus4;

  // A redirect from decode is only honoured when decode itself advances.
  assign w_redir     = pcSrcD & ~stallD;
  assign w_req_plus4 = r_req_addr + ADDR_W'(PC_INCR);
  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_req_addr;

  // Next-state, PC, request address and IF/ID load selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_f_nxt     = r_pc_f;
    w_req_addr_nxt = r_req_addr;
    w_drop_nxt     = r_drop;
    w_hold_we      = 1'b0;
    w_load         = 1'b0;
    w_ld_instr     = imem_rdata;
    w_ld_pc4       = w_req_plus4;
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        if (w_redir) begin
          w_pc_f_nxt     = pcBranchD;
          w_req_addr_nxt = pcBranchD;
        end else begin
          w_pc_f_nxt = r_pc_f;
        end
      end
      REQ: begin
        if (w_redir) begin
          w_pc_f_nxt = pcBranchD;
          if (imem_ack) begin
            w_req_addr_nxt = pcBranchD;
            w_drop_nxt     = 1'b0;
          end else begin
            // In-flight request cannot be withdrawn; discard it when it lands.
            w_drop_nxt = 1'b1;
          end
        end else if (imem_ack) begin
          if (r_drop) begin
            w_drop_nxt     = 1'b0;
            w_req_addr_nxt = r_pc_f;
          end else if (stallD) begin
            w_hold_we   = 1'b1;
            w_pc_f_nxt  = w_req_plus4;
            w_state_nxt = HOLD;
          end else begin
            w_load = 1'b1;
            if (!stallF) begin
              w_pc_f_nxt     = w_req_plus4;
              w_req_addr_nxt = w_req_plus4;
            end else begin
              w_pc_f_nxt = r_pc_f;
            end
          end
        end else begin
          w_req_addr_nxt = r_req_addr;
        end
      end
      HOLD: begin
        if (w_redir) begin
          w_pc_f_nxt     = pcBranchD;
          w_req_addr_nxt = pcBranchD;
          w_state_nxt    = REQ;
        end else if (!stallD) begin
          w_load         = 1'b1;
          w_ld_instr     = r_hold_instr;
          w_ld_pc4       = r_hold_pc4;
          w_req_addr_nxt = r_pc_f;
          w_state_nxt    = REQ;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Fetch control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc_f     <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc_f     <= w_pc_f_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  // Hold buffer for a word that arrived while decode was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= INSTR_W'(NOP_INSTR);
      r_hold_pc4   <= {ADDR_W{1'b0}};
    end else if (w_hold_we) begin
      r_hold_instr <= imem_rdata;
      r_hold_pc4   <= w_req_plus4;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (~stallD),
    .i_clr     (w_redir),
    .i_instr   (w_load ? w_ld_instr : INSTR_W'(NOP_INSTR)),
    .i_pc_plus4(w_load ? w_ld_pc4 : {ADDR_W{1'b0}}),
    .i_valid   (w_load),
    .o_instr   (instrD),
    .o_pc_plus4(pcPlus4D),
    .o_valid   (validD)
  );

`ifdef FETCH_PERF_EN
  logic        w_squash;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;

  assign w_squash = ((r_state == REQ) & imem_ack & (r_drop | w_redir)) |
                    ((r_state == HOLD) & w_redir);

  // Wrapping event counters for fetched and discarded words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched  <= 32'd0;
      r_perf_squashed <= 32'd0;
    end else begin
      r_perf_fetched  <= r_perf_fetched + {31'd0, w_load};
      r_perf_squashed <= r_perf_squashed + {31'd0, w_squash};
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized instruction-stream check.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, stallD, pcSrcD;
  logic [31:0] pcBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] pcPlus4D;
  logic        validD;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stallF    (stallF),
    .stallD    (stallD),
    .pcSrcD    (pcSrcD),
    .pcBranchD (pcBranchD),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (ack),
    .imem_rdata(imem_rdata),
    .instrD    (instrD),
    .pcPlus4D  (pcPlus4D),
    .validD    (validD)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_squashed(perf_squashed)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_stall(input logic s);
    stallF = s;
    stallD = s;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] a);
    check({tag, "_valid"}, {31'd0, validD}, 32'd1);
    check({tag, "_instr"}, instrD, mem_word(a));
    check({tag, "_pc4"}, pcPlus4D, a + 32'd4);
  endtask

  logic [31:0] p_instr, p_pc4, exp_pc, p_addr, tgt;
  logic        p_valid, p_req, p_stall, p_redir, p_ack, s, p, first;
  int          idle, delivered;

  initial begin
    rst_n = 1'b0; set_stall(1'b0); pcSrcD = 1'b0; pcBranchD = 32'd0; ack = 1'b0;
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", instrD, 32'd0);
    check("rst_pc4", pcPlus4D, 32'd0);
    check("rst_valid", {31'd0, validD}, 32'd0);

    // Streaming with ack tied high: one address per cycle, IF/ID one cycle behind.
    ack = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stream_req", {31'd0, imem_req}, 32'd1);
      check("stream_addr", imem_addr, 32'(4 * k));
      if (k >= 1) expect_word("stream", 32'(4 * (k - 1)));
      else check("stream_first_valid", {31'd0, validD}, 32'd0);
    end

    // Three stalled cycles: IF/ID frozen, acked word held, no skip after release.
    set_stall(1'b1);
    repeat (3) begin
      @(negedge clk);
      expect_word("stall_frozen", 32'h8);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    set_stall(1'b0);
    @(negedge clk);
    expect_word("stall_release", 32'hC);
    check("stall_release_addr", imem_addr, 32'h10);
    @(negedge clk);
    expect_word("stall_next", 32'h10);
    check("stall_next_addr", imem_addr, 32'h14);

    // Slow memory: request stable, bubbles while waiting.
    ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'h14);
      check("wait_valid", {31'd0, validD}, 32'd0);
    end
    ack = 1'b1;
    @(negedge clk);
    expect_word("wait_done", 32'h14);
    check("wait_done_addr", imem_addr, 32'h18);

    // Redirect while a request to 0x20 is still pending.
    repeat (2) @(negedge clk);
    check("pre_drop_addr", imem_addr, 32'h20);
    ack = 1'b0; pcSrcD = 1'b1; pcBranchD = 32'h100;
    @(negedge clk);
    pcSrcD = 1'b0;
    check("drop_addr_held", imem_addr, 32'h20);
    check("drop_req_held", {31'd0, imem_req}, 32'd1);
    check("drop_bubble", {31'd0, validD}, 32'd0);
    ack = 1'b1;
    @(negedge clk);
    check("drop_next_addr", imem_addr, 32'h100);
    check("drop_no_word", {31'd0, validD}, 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_squash1", perf_squashed, 32'd1);
`endif
    @(negedge clk);
    expect_word("target", 32'h100);

    // pcSrcD during a decode stall has no effect.
    set_stall(1'b1); pcSrcD = 1'b1; pcBranchD = 32'h200;
    repeat (2) begin
      @(negedge clk);
      expect_word("ign_frozen", 32'h100);
    end
    set_stall(1'b0); pcSrcD = 1'b0;
    @(negedge clk);
    expect_word("ign_release", 32'h104);
    check("ign_addr", imem_addr, 32'h108);

    // Redirect out of HOLD: buffered word discarded.
    set_stall(1'b1);
    @(negedge clk);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    set_stall(1'b0); pcSrcD = 1'b1; pcBranchD = 32'h300;
    @(negedge clk);
    pcSrcD = 1'b0;
    check("hredir_valid", {31'd0, validD}, 32'd0);
    check("hredir_addr", imem_addr, 32'h300);
    check("hredir_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    expect_word("hredir_target", 32'h300);
`ifdef FETCH_PERF_EN
    check("perf_squash2", perf_squashed, 32'd2);
`endif

    // Redirect with same-cycle ack to the top of the address space, then wrap.
    pcSrcD = 1'b1; pcBranchD = 32'hFFFF_FFFC;
    @(negedge clk);
    pcSrcD = 1'b0;
    check("wrap_bubble", {31'd0, validD}, 32'd0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    expect_word("wrap", 32'hFFFF_FFFC);
    check("wrap_pc4_zero", pcPlus4D, 32'd0);
    check("wrap_next_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_squash3", perf_squashed, 32'd3);
`endif

    // Asynchronous reset mid-request drops it at once.
    ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_valid", {31'd0, validD}, 32'd0);
    check("async_rst_addr", imem_addr, 32'd0);

    // Random phase: delivered words must form the program-order stream with redirects.
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'd0; first = 1'b1; idle = 0; delivered = 0;
    p_stall = 1'b0; p_redir = 1'b0; p_ack = 1'b0; p_req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!first) begin
        if (p_stall) begin
          check("rnd_freeze_instr", instrD, p_instr);
          check("rnd_freeze_pc4", pcPlus4D, p_pc4);
          check("rnd_freeze_valid", {31'd0, validD}, {31'd0, p_valid});
        end else if (p_redir) begin
          check("rnd_redir_bubble", {31'd0, validD}, 32'd0);
        end else if (validD) begin
          check("rnd_instr", instrD, mem_word(exp_pc));
          check("rnd_pc4", pcPlus4D, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          idle = 0;
          delivered++;
        end else begin
          idle++;
          if (idle > 60) begin
            check("rnd_liveness", 32'(idle), 32'd0);
            idle = 0;
          end
        end
        if (p_req && !p_ack) begin
          check("rnd_req_stable", {31'd0, imem_req}, 32'd1);
          check("rnd_addr_stable", imem_addr, p_addr);
        end
      end
      first = 1'b0;
      p_instr = instrD; p_pc4 = pcPlus4D; p_valid = validD;
      p_req = imem_req; p_addr = imem_addr;
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else tgt = 32'(4 * $urandom_range(0, 1023));
      set_stall(s); pcSrcD = p; pcBranchD = tgt;
      ack = ($urandom_range(0, 2) != 0);
      p_stall = s; p_redir = p & ~s; p_ack = ack;
      if (p_redir) begin
        exp_pc = tgt;
        idle = 0;
      end
    end
    check("rnd_progress", {31'd0, delivered > 500}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
